// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Contents: RV32 load/store funct3 encodings, the unit's state type, and
// helpers that classify a request as misaligned or as using an illegal funct3.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      ACCESS,
      WRITE,
      RESP,
      ERR
   } lsu_state_t;

   // funct3[1:0] encodes the access size for both signed and unsigned loads.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      logic mis;
      mis = 1'b0;
      case (funct3[1:0])
         2'b01:   mis = offset[0];
         2'b10:   mis = (offset != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic is_illegal_f3(input logic we, input logic [2:0] funct3);
      logic bad;
      if (we) begin
         bad = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
      end else begin
         bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment for 32-bit data words.
// Ports:
//   i_funct3      access size / signedness (RV32 encoding)
//   i_offset      byte offset within the word (addr[1:0])
//   i_rdata       word read from memory
//   i_wdata       store data; low byte/halfword used for sub-word stores
//   o_load_data   selected lane, sign- or zero-extended
//   o_store_data  i_rdata with the store lane replaced by i_wdata
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_data
);

   logic [4:0]  w_bit_base;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_bit_base = {i_offset, 3'b000};
   assign w_byte     = i_rdata[w_bit_base +: 8];
   assign w_half     = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_load_data = i_rdata;
      case (i_funct3)
         F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_load_data = {24'h0, w_byte};
         F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_load_data = {16'h0, w_half};
         default: o_load_data = i_rdata;
      endcase
   end

   always_comb begin
      o_store_data = i_rdata;
      case (i_funct3)
         F3_B: o_store_data[w_bit_base +: 8] = i_wdata[7:0];
         F3_H: begin
            if (i_offset[1]) begin
               o_store_data[31:16] = i_wdata[15:0];
            end else begin
               o_store_data[15:0] = i_wdata[15:0];
            end
         end
         default: o_store_data = i_wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: initiator side of a word-addressed data memory with
// combinational read and synchronous write. Sub-word stores are done as
// read-modify-write; misaligned, out-of-range and illegal-funct3 requests
// complete with an error response and never touch memory.
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_req_valid/o_req_ready              request handshake (ready only in IDLE)
//   i_req_we/i_req_funct3/i_req_addr/i_req_wdata   request payload
//   o_resp_valid/o_resp_rdata/o_resp_error         one-cycle completion pulse
//   o_mem_we/o_mem_addr/o_mem_wdata/i_mem_rdata    data memory port
// ADDR_WIDTH must be <= 29 so the out-of-range field is non-empty; DATA_WIDTH must be 32.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [2:0]            i_req_funct3,
   input  logic [31:0]           i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_resp_valid,
   output logic [DATA_WIDTH-1:0] o_resp_rdata,
   output logic                  o_resp_error,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

   lsu_state_t r_state;
   lsu_state_t w_state_next;

   logic                  r_we;
   logic [2:0]            r_funct3;
   logic [1:0]            r_offset;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [DATA_WIDTH-1:0] r_resp_rdata;

   logic                  w_accept;
   logic                  w_req_error;
   logic                  w_out_of_range;
   logic [DATA_WIDTH-1:0] w_load_data;
   logic [DATA_WIDTH-1:0] w_store_data;

   assign w_accept       = i_req_valid && (r_state == IDLE);
   assign w_out_of_range = |i_req_addr[31:ADDR_WIDTH+2];
   assign w_req_error    = is_illegal_f3(i_req_we, i_req_funct3) ||
                           is_misaligned(i_req_funct3, i_req_addr[1:0]) ||
                           w_out_of_range;

   // r_mem_wdata holds the raw store data until ACCESS, where sub-word stores
   // overwrite it with the merged word for the WRITE cycle.
   lsu_lane_align u_lane_align (
      .i_funct3     (r_funct3),
      .i_offset     (r_offset),
      .i_rdata      (i_mem_rdata),
      .i_wdata      (r_mem_wdata),
      .o_load_data  (w_load_data),
      .o_store_data (w_store_data)
   );

   // Next state and state-decoded outputs. mem_we comes only from r_state so an
   // asynchronous reset removes it immediately, preventing a partial write.
   always_comb begin
      w_state_next = r_state;
      o_req_ready  = 1'b0;
      o_resp_valid = 1'b0;
      o_resp_error = 1'b0;
      o_mem_we     = 1'b0;
      unique case (r_state)
         IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               w_state_next = w_req_error ? ERR : ACCESS;
            end
         end
         ACCESS: begin
            if (r_we && (r_funct3 != F3_W)) begin
               w_state_next = WRITE;
            end else begin
               o_mem_we     = r_we;
               w_state_next = RESP;
            end
         end
         WRITE: begin
            o_mem_we     = 1'b1;
            w_state_next = RESP;
         end
         RESP: begin
            o_resp_valid = 1'b1;
            w_state_next = IDLE;
         end
         ERR: begin
            o_resp_valid = 1'b1;
            o_resp_error = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_we         <= 1'b0;
         r_funct3     <= 3'b000;
         r_offset     <= 2'b00;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_resp_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_we         <= i_req_we;
            r_funct3     <= i_req_funct3;
            r_offset     <= i_req_addr[1:0];
            r_mem_addr   <= i_req_addr[ADDR_WIDTH+1:2];
            r_resp_rdata <= '0;
            if (i_req_we) begin
               r_mem_wdata <= i_req_wdata;
            end
         end
         if (r_state == ACCESS) begin
            if (!r_we) begin
               r_resp_rdata <= w_load_data;
            end else if (r_funct3 != F3_W) begin
               r_mem_wdata <= w_store_data;
            end
         end
      end
   end

   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data memory
// (combinational read, synchronous write) and an expected-response queue.
module tb_load_store_unit;

   localparam int AW = 10;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [2:0]    req_funct3 = 3'b000;
   logic [31:0]   req_addr = 32'h0;
   logic [31:0]   req_wdata = 32'h0;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_error;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [31:0]   pre_data = 32'h0;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else if (pre_we) mem[pre_addr] <= pre_data;
   end

   load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_funct3 (req_funct3),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_resp_valid (resp_valid),
      .o_resp_rdata (resp_rdata),
      .o_resp_error (resp_error),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .i_mem_rdata  (mem_rdata)
   );

   // Called at posedge+1 with the DUT idle.
   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   // Issue one request and check its response, latency and memory-write cycle.
   // exp_we_at is the post-accept cycle in which mem_we must be high (0 = never).
   task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int exp_we_at);
      exp_t e;
      int   lat, we_cnt, we_at, exp_cnt;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL %s ready: got %b expected 1", name, req_ready);
      else n_pass++;
      sb_q.push_back('{rdata: exp_rd, err: exp_err});
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      lat = 1; we_cnt = 0; we_at = 0;
      while (resp_valid !== 1'b1 && lat < 12) begin
         if (mem_we === 1'b1) begin we_cnt++; we_at = lat; end
         @(posedge clk); #1;
         lat++;
      end
      if (mem_we === 1'b1) we_cnt++;
      n_checks++;
      if (resp_valid !== 1'b1) begin
         $display("FAIL %s timeout: no resp_valid within %0d cycles", name, lat);
         void'(sb_q.pop_front());
      end else begin
         n_pass++;
         e = sb_q.pop_front();
         n_checks++;
         if (resp_rdata !== e.rdata)
            $display("FAIL %s rdata: got %h expected %h", name, resp_rdata, e.rdata);
         else n_pass++;
         n_checks++;
         if (resp_error !== e.err)
            $display("FAIL %s error: got %b expected %b", name, resp_error, e.err);
         else n_pass++;
         n_checks++;
         if (lat != exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
         else n_pass++;
         exp_cnt = (exp_we_at > 0) ? 1 : 0;
         n_checks++;
         if (we_cnt != exp_cnt || we_at != exp_we_at)
            $display("FAIL %s mem_we: got %0d pulses at cycle %0d expected %0d at cycle %0d",
                     name, we_cnt, we_at, exp_cnt, exp_we_at);
         else n_pass++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b0) $display("FAIL %s pulse: resp_valid got %b expected 0", name, resp_valid);
      else n_pass++;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({resp_valid, resp_error, mem_we} !== 3'b000 || resp_rdata !== 32'h0 ||
          mem_addr !== '0 || mem_wdata !== 32'h0)
         $display("FAIL reset values: got valid=%b err=%b we=%b rdata=%h addr=%h wdata=%h expected all 0",
                  resp_valid, resp_error, mem_we, resp_rdata, mem_addr, mem_wdata);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL reset ready: got %b expected 1", req_ready);
      else n_pass++;
   endtask

   task automatic test_loads();
      preload(AW'(1), 32'h8899AABB);
      do_req("lb_5",  1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
      do_req("lbu_7", 1'b0, 3'b100, 32'h7, 32'h0, 32'h00000088, 1'b0, 2, 0);
      do_req("lh_6",  1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
      do_req("lhu_4", 1'b0, 3'b101, 32'h4, 32'h0, 32'h0000AABB, 1'b0, 2, 0);
      do_req("lw_4",  1'b0, 3'b010, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 2, 0);
   endtask

   task automatic test_subword_stores();
      preload(AW'(1), 32'h8899AABB);
      do_req("sb_4", 1'b1, 3'b000, 32'h4, 32'h12345677, 32'h0, 1'b0, 3, 2);
      n_checks++;
      if (mem[1] !== 32'h8899AA77) $display("FAIL sb_4 mem: got %h expected 8899aa77", mem[1]);
      else n_pass++;
      do_req("sh_6", 1'b1, 3'b001, 32'h6, 32'h0000CAFE, 32'h0, 1'b0, 3, 2);
      n_checks++;
      if (mem[1] !== 32'hCAFEAA77) $display("FAIL sh_6 mem: got %h expected cafeaa77", mem[1]);
      else n_pass++;
   endtask

   task automatic test_word_store();
      preload(AW'(1), 32'h8899AABB);
      preload(AW'(2), 32'h0);
      do_req("sw_8", 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
      n_checks++;
      if (mem[2] !== 32'hDEADBEEF) $display("FAIL sw_8 mem: got %h expected deadbeef", mem[2]);
      else n_pass++;
      do_req("lw_8", 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
   endtask

   task automatic test_errors();
      preload(AW'(1), 32'h8899AABB);
      do_req("err_lw_6",    1'b0, 3'b010, 32'h6,    32'h0,    32'h0, 1'b1, 1, 0);
      do_req("err_sh_5",    1'b1, 3'b001, 32'h5,    32'hFFFF, 32'h0, 1'b1, 1, 0);
      do_req("err_lb_1000", 1'b0, 3'b000, 32'h1000, 32'h0,    32'h0, 1'b1, 1, 0);
      do_req("err_f3_011",  1'b0, 3'b011, 32'h4,    32'h0,    32'h0, 1'b1, 1, 0);
      n_checks++;
      if (mem[1] !== 32'h8899AABB) $display("FAIL err mem: got %h expected 8899aabb", mem[1]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      int resp_seen;
      preload(AW'(1), 32'h8899AABB);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h4;
      req_wdata = 32'h12345677;
      @(posedge clk); #1;            // ACCESS
      req_valid = 1'b0;
      @(posedge clk); #1;            // WRITE
      n_checks++;
      if (mem_we !== 1'b1) $display("FAIL rst_mid write: mem_we got %b expected 1", mem_we);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (mem_we !== 1'b0) $display("FAIL rst_mid we_drop: mem_we got %b expected 0", mem_we);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (mem[1] !== 32'h8899AABB) $display("FAIL rst_mid mem: got %h expected 8899aabb", mem[1]);
      else n_pass++;
      @(negedge clk) rst_n = 1'b1;
      resp_seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) resp_seen++;
      end
      n_checks++;
      if (resp_seen != 0) $display("FAIL rst_mid resp: got %0d pulses expected 0", resp_seen);
      else n_pass++;
      do_req("rst_mid_lw_4", 1'b0, 3'b010, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 2, 0);
   endtask

   task automatic test_back_to_back();
      logic        we_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [2:0]  f3_t [4] = '{3'b010, 3'b010, 3'b100, 3'b001};
      logic [31:0] ad_t [4] = '{32'h8, 32'h8, 32'h5, 32'h5};
      logic [31:0] wd_t [4] = '{32'h11223344, 32'h0, 32'h0, 32'h0};
      logic [31:0] rd_t [4] = '{32'h0, 32'h11223344, 32'h000000AA, 32'h0};
      logic        er_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int acc_cyc [4];
      int got;
      preload(AW'(1), 32'h8899AABB);
      got = 0;
      fork
         begin
            int cyc;
            logic rdy, acc;
            cyc = 0;
            for (int i = 0; i < 4; i++) begin
               sb_q.push_back('{rdata: rd_t[i], err: er_t[i]});
               req_valid = 1'b1; req_we = we_t[i]; req_funct3 = f3_t[i];
               req_addr = ad_t[i]; req_wdata = wd_t[i];
               acc = 1'b0;
               for (int c = 0; c < 20 && !acc; c++) begin
                  rdy = req_ready;
                  @(posedge clk); #1;
                  cyc++;
                  if (rdy === 1'b1) acc = 1'b1;
               end
               acc_cyc[i] = cyc;
               n_checks++;
               if (!acc) $display("FAIL b2b accept %0d: not accepted within 20 cycles", i);
               else n_pass++;
            end
            req_valid = 1'b0;
         end
         begin
            exp_t e;
            for (int c = 0; c < 30; c++) begin
               @(posedge clk); #1;
               if (resp_valid === 1'b1) begin
                  got++;
                  n_checks++;
                  if (sb_q.size() == 0) begin
                     $display("FAIL b2b extra resp: got rdata %h with no request pending", resp_rdata);
                  end else begin
                     e = sb_q.pop_front();
                     if (resp_rdata !== e.rdata || resp_error !== e.err)
                        $display("FAIL b2b resp %0d: got %h/%b expected %h/%b",
                                 got, resp_rdata, resp_error, e.rdata, e.err);
                     else n_pass++;
                  end
               end
            end
         end
      join
      n_checks++;
      if (got != 4) $display("FAIL b2b count: got %0d responses expected 4", got);
      else n_pass++;
      for (int i = 1; i < 4; i++) begin
         n_checks++;
         if (acc_cyc[i] - acc_cyc[i-1] != 3)
            $display("FAIL b2b interval %0d: got %0d cycles expected 3", i, acc_cyc[i] - acc_cyc[i-1]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_subword_stores();
      test_word_store();
      test_errors();
      test_reset_mid_op();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
